// File: rtl/fl_ip_proto_decoder_if.sv
// FrameLink 64-bit stream bundle: the source side uses master, the sink side uses slave.
interface fl_ip_proto_decoder_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] data;
  logic [2:0]            rem;
  logic                  sof_n;
  logic                  eof_n;
  logic                  sop_n;
  logic                  eop_n;
  logic                  src_rdy_n;
  logic                  dst_rdy_n;

  modport master (
    output data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
    input  dst_rdy_n
  );

  modport slave (
    input  data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
    output dst_rdy_n
  );
endinterface

// File: rtl/fl_ip_proto_decoder.sv
// Passive FrameLink classifier: forwards the stream unchanged and emits one
// L3 / protocol / L4 classification per frame on a ready/valid result port.
module fl_ip_proto_decoder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  fl_ip_proto_decoder_if.slave  rx,
  fl_ip_proto_decoder_if.master tx,
  output logic [1:0]            RES_L3,
  output logic [7:0]            RES_PROTO,
  output logic [3:0]            RES_L4,
  output logic                  RES_SRC_RDY_N,
  input  logic                  RES_DST_RDY_N
);
  generate
    if (DATA_WIDTH != 64) begin : g_bad_width
      $error("fl_ip_proto_decoder supports only DATA_WIDTH = 64");
    end
  endgenerate

  localparam logic [1:0]  L3_NONIP     = 2'd0;
  localparam logic [1:0]  L3_IPV4      = 2'd1;
  localparam logic [1:0]  L3_IPV6      = 2'd2;
  localparam logic [1:0]  L3_MALFORMED = 2'd3;
  localparam logic [15:0] ET_IPV4      = 16'h0800;
  localparam logic [15:0] ET_IPV6      = 16'h86DD;

  typedef enum logic [1:0] {IDLE, W1, W2, REST} state_t;

  state_t      state_reg, state_next;
  logic [15:0] ethertype_reg, ethertype_next;
  logic [3:0]  version_reg, version_next;
  logic [1:0]  l3_reg, l3_next;
  logic [7:0]  proto_reg, proto_next;
  logic        res_valid_reg, res_valid_next;
  logic [1:0]  res_l3_reg, res_l3_next;
  logic [7:0]  res_proto_reg, res_proto_next;
  logic [3:0]  res_l4_reg, res_l4_next;

  logic        sof, eof, stall, dst_rdy_n, xfer;
  logic [15:0] rx_ethertype;
  logic [3:0]  rx_version;
  logic [1:0]  w2_l3;
  logic [7:0]  w2_proto;
  logic        commit;
  logic [1:0]  commit_l3;
  logic [7:0]  commit_proto;

  function automatic logic [3:0] l4_map(input logic [7:0] p);
    case (p)
      8'd6:    l4_map = 4'd1;
      8'd17:   l4_map = 4'd2;
      8'd1:    l4_map = 4'd3;
      8'd58:   l4_map = 4'd4;
      8'd4:    l4_map = 4'd5;
      8'd41:   l4_map = 4'd6;
      8'd97:   l4_map = 4'd7;
      8'd255:  l4_map = 4'd8;
      default: l4_map = 4'd0;
    endcase
  endfunction

  assign sof = ~rx.sof_n;
  assign eof = ~rx.eof_n;
  // Hold the EOF beat while an unread result still occupies the result register.
  assign stall     = eof & res_valid_reg & RES_DST_RDY_N;
  assign dst_rdy_n = tx.dst_rdy_n | stall;
  assign xfer      = ~rx.src_rdy_n & ~dst_rdy_n;

  assign rx.dst_rdy_n = dst_rdy_n;
  assign tx.data      = rx.data;
  assign tx.rem       = rx.rem;
  assign tx.sof_n     = rx.sof_n;
  assign tx.eof_n     = rx.eof_n;
  assign tx.sop_n     = rx.sop_n;
  assign tx.eop_n     = rx.eop_n;
  assign tx.src_rdy_n = rx.src_rdy_n | stall;

  assign rx_ethertype = {rx.data[39:32], rx.data[47:40]};
  assign rx_version   = rx.data[55:52];

  always_comb begin
    w2_l3    = L3_NONIP;
    w2_proto = 8'h00;
    if (ethertype_reg == ET_IPV4) begin
      if (version_reg == 4'd4) begin
        w2_l3    = L3_IPV4;
        w2_proto = rx.data[63:56];
      end else begin
        w2_l3 = L3_MALFORMED;
      end
    end else if (ethertype_reg == ET_IPV6) begin
      if (version_reg == 4'd6) begin
        w2_l3    = L3_IPV6;
        w2_proto = rx.data[39:32];
      end else begin
        w2_l3 = L3_MALFORMED;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ethertype_next = ethertype_reg;
    version_next   = version_reg;
    l3_next        = l3_reg;
    proto_next     = proto_reg;
    commit         = 1'b0;
    commit_l3      = L3_NONIP;
    commit_proto   = 8'h00;
    if (xfer) begin
      // A SOF word always restarts parsing, even in the middle of a frame.
      if (sof) begin
        if (eof) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = W1;
        end
      end else begin
        unique case (state_reg)
          IDLE: state_next = IDLE;
          W1: begin
            ethertype_next = rx_ethertype;
            version_next   = rx_version;
            if (eof) begin
              commit     = 1'b1;
              state_next = IDLE;
              if (rx.rem < 3'd5)
                commit_l3 = L3_NONIP;
              else if (rx.rem == 3'd5)
                commit_l3 = L3_MALFORMED;
              else if (rx_ethertype == ET_IPV4 || rx_ethertype == ET_IPV6)
                commit_l3 = L3_MALFORMED;
              else
                commit_l3 = L3_NONIP;
            end else begin
              state_next = W2;
            end
          end
          W2: begin
            if (eof) begin
              commit     = 1'b1;
              state_next = IDLE;
              if ((w2_l3 == L3_IPV4 && rx.rem != 3'd7) ||
                  (w2_l3 == L3_IPV6 && rx.rem < 3'd4)) begin
                commit_l3 = L3_MALFORMED;
              end else begin
                commit_l3    = w2_l3;
                commit_proto = w2_proto;
              end
            end else begin
              l3_next    = w2_l3;
              proto_next = w2_proto;
              state_next = REST;
            end
          end
          REST: begin
            if (eof) begin
              commit       = 1'b1;
              commit_l3    = l3_reg;
              commit_proto = proto_reg;
              state_next   = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    res_valid_next = res_valid_reg;
    res_l3_next    = res_l3_reg;
    res_proto_next = res_proto_reg;
    res_l4_next    = res_l4_reg;
    if (commit) begin
      res_valid_next = 1'b1;
      res_l3_next    = commit_l3;
      res_proto_next = commit_proto;
      res_l4_next    = (commit_l3 == L3_IPV4 || commit_l3 == L3_IPV6) ? l4_map(commit_proto) : 4'd0;
    end else if (res_valid_reg && !RES_DST_RDY_N) begin
      res_valid_next = 1'b0;
      res_l3_next    = L3_NONIP;
      res_proto_next = 8'h00;
      res_l4_next    = 4'd0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      ethertype_reg <= 16'h0000;
      version_reg   <= 4'd0;
      l3_reg        <= L3_NONIP;
      proto_reg     <= 8'h00;
      res_valid_reg <= 1'b0;
      res_l3_reg    <= L3_NONIP;
      res_proto_reg <= 8'h00;
      res_l4_reg    <= 4'd0;
    end else begin
      state_reg     <= state_next;
      ethertype_reg <= ethertype_next;
      version_reg   <= version_next;
      l3_reg        <= l3_next;
      proto_reg     <= proto_next;
      res_valid_reg <= res_valid_next;
      res_l3_reg    <= res_l3_next;
      res_proto_reg <= res_proto_next;
      res_l4_reg    <= res_l4_next;
    end
  end

  assign RES_L3        = res_l3_reg;
  assign RES_PROTO     = res_proto_reg;
  assign RES_L4        = res_l4_reg;
  assign RES_SRC_RDY_N = ~res_valid_reg;
endmodule
